// File: rtl/prog_mem_loader.sv
// Program memory with a byte-stream loader: the host streams big-endian bytes
// into word storage while the CPU is held in reset, and the CPU reads that storage combinationally.
module prog_mem_loader #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] memaddr,
  output logic [31:0] memdata,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  input  logic        ld_end,
  output logic        cpu_hold,
  output logic [15:0] word_count,
  output logic        overflow
);

  localparam int                 DEPTH   = 1 << ADDR_BITS;
  localparam logic [16:0]        DEPTH_L = 17'(DEPTH);
  localparam logic [ADDR_BITS:0] FULL    = {1'b1, {ADDR_BITS{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, PAD} state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS:0]   wptr_q, wptr_d;
  logic [1:0]           idx_q, idx_d;
  logic [31:0]          asm_q, asm_d;
  logic [15:0]          wc_q, wc_d;
  logic                 ovf_q, ovf_d;

  logic [31:0]          mem [DEPTH];
  logic                 commit;
  logic                 we;
  logic [31:0]          wdata;
  logic [31:0]          asm_sh;
  logic [1:0]           idx_sh;

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    idx_d    = idx_q;
    asm_d    = asm_q;
    wc_d     = wc_q;
    ovf_d    = ovf_q;
    commit   = 1'b0;
    we       = 1'b0;
    wdata    = asm_q;
    asm_sh   = asm_q;
    idx_sh   = idx_q;
    ld_ready = 1'b0;
    cpu_hold = 1'b0;

    case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d = LOAD;
          wptr_d  = '0;
          idx_d   = '0;
          asm_d   = '0;
          wc_d    = '0;
          ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        cpu_hold = 1'b1;
        if (ld_start) begin
          // restart drops any byte offered in the same cycle
          wptr_d = '0;
          idx_d  = '0;
          asm_d  = '0;
          wc_d   = '0;
          ovf_d  = 1'b0;
        end else begin
          if (ld_valid) begin
            asm_sh = {asm_q[23:0], ld_data};
            idx_sh = idx_q + 2'd1;
            commit = (idx_q == 2'd3);
          end
          asm_d = asm_sh;
          idx_d = idx_sh;
          wdata = asm_sh;
          if (ld_end) state_d = (idx_sh == 2'd0) ? IDLE : PAD;
        end
      end
      PAD: begin
        cpu_hold = 1'b1;
        commit   = 1'b1;
        case (idx_q)
          2'd1:    wdata = {asm_q[7:0],  24'h0};
          2'd2:    wdata = {asm_q[15:0], 16'h0};
          default: wdata = {asm_q[23:0], 8'h0};
        endcase
        idx_d   = '0;
        asm_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      if (wptr_q == FULL) begin
        ovf_d = 1'b1;
      end else begin
        we     = 1'b1;
        wptr_d = wptr_q + 1'b1;
        wc_d   = wc_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      wc_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      wc_q    <= wc_d;
      ovf_q   <= ovf_d;
    end
  end

  // storage survives reset; only the write is blocked while reset is high
  always_ff @(posedge clk) begin
    if (we && !reset) mem[wptr_q[ADDR_BITS-1:0]] <= wdata;
  end

  assign memdata    = ({1'b0, memaddr} >= DEPTH_L) ? 32'hF000_0000
                                                   : mem[memaddr[ADDR_BITS-1:0]];
  assign word_count = wc_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: a 1024-word and a 4-word instance share the stimulus and are
// compared against constant tables, hand sequences and a byte-level session model.
module tb_prog_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] memaddr = '0;
  logic        ld_start = 1'b0, ld_valid = 1'b0, ld_end = 1'b0;
  logic [7:0]  ld_data = '0;

  logic [31:0] md_a, md_b;
  logic        rdy_a, rdy_b, hold_a, hold_b, ovf_a, ovf_b;
  logic [15:0] wc_a, wc_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  prog_mem_loader #(.ADDR_BITS(10)) dut_a (
    .clk(clk), .reset(reset), .memaddr(memaddr), .memdata(md_a),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(rdy_a),
    .ld_end(ld_end), .cpu_hold(hold_a), .word_count(wc_a), .overflow(ovf_a));

  prog_mem_loader #(.ADDR_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .memaddr(memaddr), .memdata(md_b),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(rdy_b),
    .ld_end(ld_end), .cpu_hold(hold_b), .word_count(wc_b), .overflow(ovf_b));

  // reference model: one session record per instance, bytes kept by position
  int        depth [2] = '{1024, 4};
  bit        m_open [2];
  bit        m_pad  [2];
  bit [7:0]  m_byte [2][4];
  int        m_n    [2];
  int        m_cnt  [2];
  bit        m_ovf  [2];
  bit [31:0] m_mem  [2][1024];
  bit        m_vld  [2][1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic clear_part(input int k);
    for (int i = 0; i < 4; i++) m_byte[k][i] = 8'h00;
    m_n[k] = 0;
  endtask

  task automatic store_word(input int k);
    bit [31:0] w;
    w = {m_byte[k][0], m_byte[k][1], m_byte[k][2], m_byte[k][3]};
    if (m_cnt[k] < depth[k]) begin
      m_mem[k][m_cnt[k]] = w;
      m_vld[k][m_cnt[k]] = 1'b1;
      m_cnt[k]++;
    end else begin
      m_ovf[k] = 1'b1;
    end
    clear_part(k);
  endtask

  task automatic new_session(input int k);
    m_open[k] = 1'b1;
    m_cnt[k]  = 0;
    m_ovf[k]  = 1'b0;
    clear_part(k);
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_open[k] = 1'b0;
        m_pad[k]  = 1'b0;
        m_cnt[k]  = 0;
        m_ovf[k]  = 1'b0;
        clear_part(k);
      end else if (m_pad[k]) begin
        store_word(k);
        m_pad[k]  = 1'b0;
        m_open[k] = 1'b0;
      end else if (m_open[k]) begin
        if (ld_start) new_session(k);
        else begin
          if (ld_valid) begin
            m_byte[k][m_n[k]] = ld_data;
            m_n[k]++;
            if (m_n[k] == 4) store_word(k);
          end
          if (ld_end) begin
            if (m_n[k] == 0) m_open[k] = 1'b0;
            else m_pad[k] = 1'b1;
          end
        end
      end else if (ld_start) begin
        new_session(k);
      end
    end
  endtask

  task automatic check_model();
    chk("model ready A", {31'b0, rdy_a}, {31'b0, m_open[0] & ~m_pad[0]});
    chk("model hold A",  {31'b0, hold_a}, {31'b0, m_open[0]});
    chk("model wc A",    {16'b0, wc_a}, 32'(m_cnt[0]));
    chk("model ovf A",   {31'b0, ovf_a}, {31'b0, m_ovf[0]});
    chk("model ready B", {31'b0, rdy_b}, {31'b0, m_open[1] & ~m_pad[1]});
    chk("model hold B",  {31'b0, hold_b}, {31'b0, m_open[1]});
    chk("model wc B",    {16'b0, wc_b}, 32'(m_cnt[1]));
    chk("model ovf B",   {31'b0, ovf_b}, {31'b0, m_ovf[1]});
    if (int'(memaddr) >= depth[0]) chk("model rd A", md_a, 32'hF000_0000);
    else if (m_vld[0][memaddr]) chk("model rd A", md_a, m_mem[0][memaddr]);
    if (int'(memaddr) >= depth[1]) chk("model rd B", md_b, 32'hF000_0000);
    else if (m_vld[1][memaddr]) chk("model rd B", md_b, m_mem[1][memaddr]);
  endtask

  task automatic cycle(input bit r, input bit st, input bit vl, input bit [7:0] d, input bit en);
    reset = r; ld_start = st; ld_valid = vl; ld_data = d; ld_end = en;
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic rd(input string name, input bit which, input logic [15:0] a,
                    input logic [31:0] exp);
    memaddr = a;
    #1;
    chk(name, which ? md_b : md_a, exp);
  endtask

  typedef struct {
    bit        rst, st, vl, en;
    bit [7:0]  d;
    bit        hold, rdy;
    int        wc;
  } vec_t;

  function automatic vec_t mk(bit r, bit st, bit vl, bit [7:0] d, bit en,
                              bit hold, bit rdy, int wc);
    vec_t v;
    v.rst = r; v.st = st; v.vl = vl; v.d = d; v.en = en;
    v.hold = hold; v.rdy = rdy; v.wc = wc;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_open[k] = 0; m_pad[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; clear_part(k);
      for (int i = 0; i < 1024; i++) m_vld[k][i] = 1'b0;
    end

    // full load, then a partial word that needs one pad cycle
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'hF0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 8'h12, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 8'h34, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 8'h56, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 8'h78, 0, 1, 1, 2));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1, 8'h99, 1, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'hAA, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'hBB, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 1));

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].st, tbl[i].vl, tbl[i].d, tbl[i].en);
      chk($sformatf("tbl%0d hold", i), {31'b0, hold_a}, {31'b0, tbl[i].hold});
      chk($sformatf("tbl%0d ready", i), {31'b0, rdy_a}, {31'b0, tbl[i].rdy});
      chk($sformatf("tbl%0d wc", i), {16'b0, wc_a}, 32'(tbl[i].wc));
      chk($sformatf("tbl%0d wcB", i), {16'b0, wc_b}, 32'(tbl[i].wc));
    end
    rd("pad word", 0, 16'd0, 32'hAABB_0000);
    rd("word1 kept", 0, 16'd1, 32'h1234_5678);
    rd("word1 kept B", 1, 16'd1, 32'h1234_5678);
    rd("end opcode A", 0, 16'h0400, 32'hF000_0000);
    rd("end opcode B", 1, 16'd4, 32'hF000_0000);

    // final byte together with ld_end: no pad cycle
    cycle(0, 1, 0, 8'h00, 0);
    cycle(0, 0, 1, 8'h01, 0);
    cycle(0, 0, 1, 8'h02, 0);
    cycle(0, 0, 1, 8'h03, 0);
    cycle(0, 0, 1, 8'h04, 1);
    chk("same-cycle end hold", {31'b0, hold_a}, 32'd0);
    chk("same-cycle end wc", {16'b0, wc_a}, 32'd1);
    rd("same-cycle end word", 0, 16'd0, 32'h0102_0304);

    // five words into the 4-word instance
    cycle(0, 1, 0, 8'h00, 0);
    for (int w = 0; w < 5; w++)
      for (int j = 0; j < 4; j++) cycle(0, 0, 1, 8'(w * 16 + j), 0);
    cycle(0, 0, 0, 8'h00, 1);
    chk("ovf wc B", {16'b0, wc_b}, 32'd4);
    chk("ovf flag B", {31'b0, ovf_b}, 32'd1);
    chk("ovf wc A", {16'b0, wc_a}, 32'd5);
    chk("ovf flag A", {31'b0, ovf_a}, 32'd0);
    rd("ovf last word B", 1, 16'd3, 32'h3031_3233);
    rd("ovf 5th word A", 0, 16'd4, 32'h4041_4243);
    cycle(0, 1, 0, 8'h00, 0);
    chk("ovf cleared B", {31'b0, ovf_b}, 32'd0);

    // reset in the middle of a session
    cycle(0, 1, 0, 8'h00, 0);
    for (int j = 0; j < 6; j++) cycle(0, 0, 1, 8'hA0 + 8'(j), 0);
    cycle(1, 0, 1, 8'hEE, 1);
    chk("mid reset hold", {31'b0, hold_a}, 32'd0);
    chk("mid reset wc", {16'b0, wc_a}, 32'd0);
    rd("mid reset storage", 0, 16'd0, 32'hA0A1_A2A3);
    cycle(1, 1, 0, 8'h00, 0);
    chk("reset beats start", {31'b0, hold_a}, 32'd0);

    // restart inside LOAD drops the concurrent byte; start during PAD is ignored
    cycle(0, 1, 0, 8'h00, 0);
    cycle(0, 0, 1, 8'h11, 0);
    cycle(0, 0, 1, 8'h22, 0);
    cycle(0, 1, 1, 8'h33, 0);
    for (int j = 5; j < 9; j++) cycle(0, 0, 1, 8'(j), 0);
    cycle(0, 0, 0, 8'h00, 1);
    chk("restart wc", {16'b0, wc_a}, 32'd1);
    rd("restart word", 0, 16'd0, 32'h0506_0708);
    cycle(0, 1, 0, 8'h00, 0);
    cycle(0, 0, 1, 8'h9A, 0);
    cycle(0, 0, 0, 8'h00, 1);
    cycle(0, 1, 0, 8'h00, 0);
    chk("start in pad hold", {31'b0, hold_a}, 32'd0);
    rd("start in pad word", 0, 16'd0, 32'h9A00_0000);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      memaddr = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
